byte_unstripping_nlane: RTL and testbench
=========================================

Name: byte_unstripping_nlane

Overview:
Parametrised successor to the two-lane byte unstriper. It merges NUM_LANES striped lanes of WIDTH-bit words back into one serial stream, in strict round-robin lane order starting at lane 0. Each lane has its own DEPTH-entry FIFO, which absorbs lane skew. Valid/ready handshakes are used on both sides, the active lane count is selectable at run time, and lane overflow is detected. The block sits between the per-lane receive path and the demux/conditioning stage, all in the clk_2f domain.

Parameters:
NUM_LANES, 4, number of input lanes (2..8)
WIDTH, 8, word width in bits
DEPTH, 4, per-lane FIFO depth; power of 2, at least 2

Ports:
clk_2f  input  1  single clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
data_stripe  input  NUM_LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
valid_stripe  input  NUM_LANES  per-lane word valid
ready_stripe  output  NUM_LANES  per-lane space available
active_lanes  input  $clog2(NUM_LANES+1)  number of lanes in rotation
data_unstripe  output  WIDTH  merged output word (registered)
valid_unstripe  output  1  output word valid (registered)
ready_unstripe  input  1  downstream accepts the output word
lane_sel  output  $clog2(NUM_LANES)  lane to be read next
overflow_err  output  1  sticky lane-overflow flag

Behaviour:
- Reset (checked on the clk_2f edge while reset=1):
  - All FIFOs are emptied and all pointers and counts go to 0.
  - lane_sel=0, data_unstripe=0, valid_unstripe=0, overflow_err=0.
  - ready_stripe is forced to all 0 while reset=1.
  - Reset asserted mid-stream discards every buffered word; there is no partial flush.
- Per-lane FIFO:
  - Count width is $clog2(DEPTH)+1; pointers wrap modulo DEPTH.
  - ready_stripe[i] = !reset && count_i != DEPTH. It is derived from the registered count only, with no same-cycle read credit.
- Write: when valid_stripe[i] && ready_stripe[i], the word is stored in FIFO i.
- Overflow: valid_stripe[i]=1 while FIFO i is full drops the word and sets overflow_err=1. overflow_err stays set until reset.
- Read and output stage:
  - The output register may load when valid_unstripe==0 || ready_unstripe==1.
  - If it may load and FIFO[lane_sel] is non-empty: pop that word into data_unstripe, set valid_unstripe=1, and advance lane_sel.
  - If it may load and FIFO[lane_sel] is empty: valid_unstripe goes to 0, data_unstripe holds, lane_sel holds.
  - Lanes are never skipped, so output order is exactly lane0, lane1, ..., lane(N_act-1), lane0, ...
  - If valid_unstripe=1 && ready_unstripe=0, all output state holds.
- Lane advance:
  - N_act = active_lanes, except that 0 or any value > NUM_LANES is treated as NUM_LANES.
  - lane_sel goes to 0 when lane_sel >= N_act-1; otherwise it goes to lane_sel+1.
  - A change to active_lanes takes effect at the next advance. It is only guaranteed order-safe when lane_sel==0.
- Inactive lanes: lanes >= N_act still accept writes but are never read. They fill, then drop words and set overflow_err.
- Simultaneous push and pop on the same lane in one cycle: both occur and the count is unchanged. A full lane popped in the same cycle as a write attempt still counts as overflow, because ready_stripe was 0.
- Latency: a word presented in cycle n to an empty lane equal to lane_sel, with the output stage free, gives valid_unstripe=1 in cycle n+2.
- Throughput: one word per clk_2f cycle when all lanes have data and ready_unstripe=1.

Test Plan:
1. Reset, then NUM_LANES=4, active_lanes=4, one word per lane in the same cycle (0xA0, 0xA1, 0xA2, 0xA3) with ready_unstripe=1 -> output is 0xA0, 0xA1, 0xA2, 0xA3 in cycles n+2..n+5; lane_sel returns to 0; valid_unstripe drops at n+6.
2. Skew: lane 0 gets 0x10 at cycle 0, lanes 1-3 get 0x11, 0x12, 0x13 at cycle 3 -> 0x10 appears at cycle 2; valid_unstripe=0 in cycles 3-4; 0x11..0x13 appear in cycles 5-7, in order.
3. Backpressure: stream 12 words, ready_unstripe=0 for 6 cycles mid-stream -> data_unstripe holds and is stable, no word is lost or duplicated, order is preserved, and ready_stripe[i] falls only when count_i=4.
4. Overflow: with ready_unstripe=0, write 5 words to lane 2 -> ready_stripe[2]=0 after the 4th word; the 5th word sets overflow_err=1 and is dropped; overflow_err stays 1 until reset.
5. active_lanes=2: words on lanes 0 and 1 -> output alternates lane 0/lane 1 and lane_sel toggles 0/1. Lane 3 written 4 times -> ready_stripe[3]=0; a 5th write sets overflow_err. active_lanes=0 behaves like 4.
6. Assert reset for 1 cycle with 3 words buffered and valid_unstripe=1 -> the next cycle shows valid_unstripe=0, data_unstripe=0, lane_sel=0, ready_stripe=4'b1111 after release, and no stale words are emitted.

Source files
------------

// File: rtl/byte_unstripping_nlane.sv
// Merges NUM_LANES striped lanes back into one serial word stream in strict round-robin order.
// Each lane has its own small FIFO to absorb skew; output is a registered valid/ready stage.
module byte_unstripping_nlane #(
    parameter int NUM_LANES = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4
) (
    input  logic                             clk_2f,
    input  logic                             reset,
    input  logic [NUM_LANES*WIDTH-1:0]       data_stripe,
    input  logic [NUM_LANES-1:0]             valid_stripe,
    output logic [NUM_LANES-1:0]             ready_stripe,
    input  logic [$clog2(NUM_LANES+1)-1:0]   active_lanes,
    output logic [WIDTH-1:0]                 data_unstripe,
    output logic                             valid_unstripe,
    input  logic                             ready_unstripe,
    output logic [$clog2(NUM_LANES)-1:0]     lane_sel,
    output logic                             overflow_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(NUM_LANES);
    localparam int AW = $clog2(NUM_LANES + 1);

    logic [WIDTH-1:0]     head_word [NUM_LANES];
    logic [NUM_LANES-1:0] lane_empty;
    logic [NUM_LANES-1:0] lane_full;
    logic [NUM_LANES-1:0] pop;
    logic [NUM_LANES-1:0] lane_ovf;

    logic [SW-1:0]    lane_sel_reg, lane_sel_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             ovf_reg;
    logic             load_ok, head_valid, advance;
    logic [AW-1:0]    n_act, last_lane;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [WIDTH-1:0] mem [DEPTH];
            logic [PW-1:0]    wr_ptr_reg;
            logic [PW-1:0]    rd_ptr_reg;
            logic [CW-1:0]    count_reg;
            logic             push;

            // Ready comes from the registered count only; a same-cycle pop gives no credit.
            assign lane_full[gi]    = (count_reg == CW'(DEPTH));
            assign lane_empty[gi]   = (count_reg == '0);
            assign ready_stripe[gi] = !reset && !lane_full[gi];
            assign push             = valid_stripe[gi] && ready_stripe[gi];
            assign lane_ovf[gi]     = !reset && valid_stripe[gi] && lane_full[gi];
            assign pop[gi]          = advance && (lane_sel_reg == SW'(gi));
            assign head_word[gi]    = mem[rd_ptr_reg];

            always_ff @(posedge clk_2f) begin
                if (push) begin
                    mem[wr_ptr_reg] <= data_stripe[gi*WIDTH +: WIDTH];
                end
            end

            always_ff @(posedge clk_2f) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    end
                    case ({push, pop[gi]})
                        2'b10:   count_reg <= count_reg + CW'(1);
                        2'b01:   count_reg <= count_reg - CW'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Zero or out-of-range lane counts fall back to the full lane set.
    always_comb begin
        n_act = active_lanes;
        if (active_lanes == '0 || active_lanes > AW'(NUM_LANES)) begin
            n_act = AW'(NUM_LANES);
        end
        last_lane = n_act - AW'(1);
    end

    assign load_ok    = !valid_reg || ready_unstripe;
    assign head_valid = !lane_empty[lane_sel_reg];
    assign advance    = load_ok && head_valid;

    always_comb begin
        lane_sel_next = lane_sel_reg;
        data_next     = data_reg;
        valid_next    = valid_reg;
        if (load_ok) begin
            if (head_valid) begin
                data_next  = head_word[lane_sel_reg];
                valid_next = 1'b1;
                if (AW'(lane_sel_reg) >= last_lane) begin
                    lane_sel_next = '0;
                end else begin
                    lane_sel_next = lane_sel_reg + SW'(1);
                end
            end else begin
                // Never skip an empty lane: wait on it so output order stays strict.
                valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            lane_sel_reg <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            lane_sel_reg <= lane_sel_next;
            data_reg     <= data_next;
            valid_reg    <= valid_next;
            ovf_reg      <= ovf_reg | (|lane_ovf);
        end
    end

    assign lane_sel       = lane_sel_reg;
    assign data_unstripe  = data_reg;
    assign valid_unstripe = valid_reg;
    assign overflow_err   = ovf_reg;

endmodule

// File: tb/tb_byte_unstripping_nlane.sv
// Directed bench for byte_unstripping_nlane: a cycle table for the basic orderings plus
// hand sequences (backpressure, overflow, mid-stream reset) checked against a queue model.
module tb_byte_unstripping_nlane;
    localparam int NL = 4;
    localparam int W  = 8;
    localparam int D  = 4;

    logic            clk_2f = 1'b0;
    logic            reset = 1'b1;
    logic [NL*W-1:0] data_stripe = '0;
    logic [NL-1:0]   valid_stripe = '0;
    logic [NL-1:0]   ready_stripe;
    logic [2:0]      active_lanes = 3'd4;
    logic [W-1:0]    data_unstripe;
    logic            valid_unstripe;
    logic            ready_unstripe = 1'b1;
    logic [1:0]      lane_sel;
    logic            overflow_err;

    int compared = 0;
    int mismatched = 0;

    always #5 clk_2f = ~clk_2f;

    byte_unstripping_nlane #(.NUM_LANES(NL), .WIDTH(W), .DEPTH(D)) dut (
        .clk_2f         (clk_2f),
        .reset          (reset),
        .data_stripe    (data_stripe),
        .valid_stripe   (valid_stripe),
        .ready_stripe   (ready_stripe),
        .active_lanes   (active_lanes),
        .data_unstripe  (data_unstripe),
        .valid_unstripe (valid_unstripe),
        .ready_unstripe (ready_unstripe),
        .lane_sel       (lane_sel),
        .overflow_err   (overflow_err)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  vin;
        logic [31:0] din;
        logic        rdy;
        logic [2:0]  act;
        logic        ev;
        logic [7:0]  ed;
        logic [1:0]  esel;
        logic [3:0]  ers;
        logic        eovf;
    } vec_t;

    vec_t tbl[$];

    logic [7:0] mq [NL][$];
    logic       m_v;
    logic [7:0] m_d;
    int         m_sel;
    logic       m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_2f);
        #1;
    endtask

    task automatic add(input logic rst, input logic [3:0] vin, input logic [31:0] din,
                       input logic rdy, input logic [2:0] act, input logic ev,
                       input logic [7:0] ed, input logic [1:0] esel, input logic [3:0] ers);
        vec_t v;
        v.rst = rst; v.vin = vin; v.din = din; v.rdy = rdy; v.act = act;
        v.ev = ev; v.ed = ed; v.esel = esel; v.ers = ers; v.eovf = 1'b0;
        tbl.push_back(v);
    endtask

    task automatic m_clear;
        for (int i = 0; i < NL; i++) mq[i].delete();
        m_v = 1'b0; m_d = '0; m_sel = 0; m_ovf = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        valid_stripe = '0;
        ready_unstripe = 1'b1;
        tick;
        reset = 1'b0;
        m_clear;
    endtask

    // One clock of stimulus, model update, then compare every output with the model.
    task automatic step(input logic [3:0] vin, input logic [31:0] din, input logic rdy,
                        input logic [2:0] act, input string tag);
        int nact;
        logic [3:0] rs;
        reset = 1'b0; valid_stripe = vin; data_stripe = din;
        ready_unstripe = rdy; active_lanes = act;
        nact = (act == 0 || act > NL) ? NL : int'(act);
        for (int i = 0; i < NL; i++) rs[i] = (mq[i].size() < D);
        if (!m_v || rdy) begin
            if (mq[m_sel].size() > 0) begin
                m_d = mq[m_sel].pop_front();
                m_v = 1'b1;
                m_sel = (m_sel >= nact - 1) ? 0 : m_sel + 1;
            end else begin
                m_v = 1'b0;
            end
        end
        for (int i = 0; i < NL; i++) begin
            if (vin[i]) begin
                if (rs[i]) mq[i].push_back(din[i*8 +: 8]);
                else m_ovf = 1'b1;
            end
        end
        tick;
        for (int i = 0; i < NL; i++) rs[i] = (mq[i].size() < D);
        check({tag, "_valid"}, valid_unstripe, m_v);
        check({tag, "_data"}, data_unstripe, m_d);
        check({tag, "_lane_sel"}, lane_sel, m_sel);
        check({tag, "_ready_stripe"}, ready_stripe, rs);
        check({tag, "_overflow"}, overflow_err, m_ovf);
    endtask

    initial begin
        int got;
        logic [7:0] held;
        logic was_stalled;

        // Test 1: one word per lane in the same cycle
        add(1, 4'h0, 32'h0, 1, 4, 0, 8'h00, 0, 4'h0);
        add(0, 4'hF, 32'hA3A2A1A0, 1, 4, 0, 8'h00, 0, 4'hF);
        add(0, 4'h0, 32'h0, 1, 4, 1, 8'hA0, 1, 4'hF);
        add(0, 4'h0, 32'h0, 1, 4, 1, 8'hA1, 2, 4'hF);
        add(0, 4'h0, 32'h0, 1, 4, 1, 8'hA2, 3, 4'hF);
        add(0, 4'h0, 32'h0, 1, 4, 1, 8'hA3, 0, 4'hF);
        add(0, 4'h0, 32'h0, 1, 4, 0, 8'hA3, 0, 4'hF);
        // Test 2: skew, lanes 1-3 arrive three cycles after lane 0
        add(1, 4'h0, 32'h0, 1, 4, 0, 8'h00, 0, 4'h0);
        add(0, 4'h1, 32'h00000010, 1, 4, 0, 8'h00, 0, 4'hF);
        add(0, 4'h0, 32'h0, 1, 4, 1, 8'h10, 1, 4'hF);
        add(0, 4'h0, 32'h0, 1, 4, 0, 8'h10, 1, 4'hF);
        add(0, 4'hE, 32'h13121100, 1, 4, 0, 8'h10, 1, 4'hF);
        add(0, 4'h0, 32'h0, 1, 4, 1, 8'h11, 2, 4'hF);
        add(0, 4'h0, 32'h0, 1, 4, 1, 8'h12, 3, 4'hF);
        add(0, 4'h0, 32'h0, 1, 4, 1, 8'h13, 0, 4'hF);
        add(0, 4'h0, 32'h0, 1, 4, 0, 8'h13, 0, 4'hF);
        // Test 5a: two active lanes alternate
        add(1, 4'h0, 32'h0, 1, 2, 0, 8'h00, 0, 4'h0);
        add(0, 4'h3, 32'h0000B1B0, 1, 2, 0, 8'h00, 0, 4'hF);
        add(0, 4'h3, 32'h0000B3B2, 1, 2, 1, 8'hB0, 1, 4'hF);
        add(0, 4'h0, 32'h0, 1, 2, 1, 8'hB1, 0, 4'hF);
        add(0, 4'h0, 32'h0, 1, 2, 1, 8'hB2, 1, 4'hF);
        add(0, 4'h0, 32'h0, 1, 2, 1, 8'hB3, 0, 4'hF);
        add(0, 4'h0, 32'h0, 1, 2, 0, 8'hB3, 0, 4'hF);
        // active_lanes=0 rotates over all four lanes
        add(1, 4'h0, 32'h0, 1, 0, 0, 8'h00, 0, 4'h0);
        add(0, 4'hF, 32'hC3C2C1C0, 1, 0, 0, 8'h00, 0, 4'hF);
        add(0, 4'h0, 32'h0, 1, 0, 1, 8'hC0, 1, 4'hF);
        add(0, 4'h0, 32'h0, 1, 0, 1, 8'hC1, 2, 4'hF);
        add(0, 4'h0, 32'h0, 1, 0, 1, 8'hC2, 3, 4'hF);
        add(0, 4'h0, 32'h0, 1, 0, 1, 8'hC3, 0, 4'hF);
        add(0, 4'h0, 32'h0, 1, 0, 0, 8'hC3, 0, 4'hF);

        foreach (tbl[i]) begin
            reset = tbl[i].rst; valid_stripe = tbl[i].vin; data_stripe = tbl[i].din;
            ready_unstripe = tbl[i].rdy; active_lanes = tbl[i].act;
            tick;
            check($sformatf("vec%0d_valid", i), valid_unstripe, tbl[i].ev);
            check($sformatf("vec%0d_data", i), data_unstripe, tbl[i].ed);
            check($sformatf("vec%0d_lane_sel", i), lane_sel, tbl[i].esel);
            check($sformatf("vec%0d_ready_stripe", i), ready_stripe, tbl[i].ers);
            check($sformatf("vec%0d_overflow", i), overflow_err, tbl[i].eovf);
        end

        // Test 3: 12 words with a 6-cycle downstream stall
        do_reset;
        got = 0;
        for (int c = 0; c < 26; c++) begin
            logic rdy;
            logic [31:0] din;
            rdy = !(c >= 4 && c < 10);
            for (int l = 0; l < NL; l++) din[l*8 +: 8] = 8'(8'h30 + c*4 + l);
            if (valid_unstripe && rdy) begin
                check("t3_order", data_unstripe, 32'(8'h30 + got));
                got++;
            end
            was_stalled = valid_unstripe && !rdy;
            held = data_unstripe;
            step((c < 3) ? 4'hF : 4'h0, din, rdy, 4, "t3");
            if (was_stalled) check("t3_hold", data_unstripe, held);
        end
        check("t3_word_count", got, 12);

        // Test 4: overflow on lane 2 with the output stalled
        do_reset;
        for (int k = 0; k < 5; k++) begin
            step(4'b0100, 32'(8'h40 + k) << 16, 1'b0, 4, "t4");
            if (k == 3) check("t4_ready2_full", ready_stripe[2], 0);
            if (k == 4) check("t4_overflow_set", overflow_err, 1);
        end
        for (int k = 0; k < 3; k++) step(4'h0, 32'h0, 1'b1, 4, "t4_idle");
        check("t4_overflow_sticky", overflow_err, 1);
        reset = 1'b1; tick;
        check("t4_overflow_cleared", overflow_err, 0);
        reset = 1'b0; m_clear;

        // Test 5b: inactive lane 3 fills and overflows while lanes 0/1 stream
        do_reset;
        for (int k = 0; k < 5; k++) begin
            step(4'b1011, {8'(8'h70 + k), 8'h00, 8'(8'h60 + k), 8'(8'h50 + k)}, 1'b1, 2, "t5");
            if (k == 3) check("t5_ready3_full", ready_stripe[3], 0);
            if (k == 4) check("t5_overflow_set", overflow_err, 1);
        end
        for (int k = 0; k < 8; k++) step(4'h0, 32'h0, 1'b1, 2, "t5_drain");

        // Test 6: reset with words buffered and the output valid
        do_reset;
        step(4'hF, 32'hD3D2D1D0, 1'b1, 4, "t6_fill");
        step(4'h0, 32'h0, 1'b1, 4, "t6_first");
        reset = 1'b1; valid_stripe = '0; ready_unstripe = 1'b1;
        tick;
        check("t6_rst_valid", valid_unstripe, 0);
        check("t6_rst_data", data_unstripe, 0);
        check("t6_rst_lane_sel", lane_sel, 0);
        check("t6_rst_ready_stripe", ready_stripe, 4'h0);
        reset = 1'b0;
        #1;
        check("t6_ready_after_release", ready_stripe, 4'hF);
        m_clear;
        for (int k = 0; k < 6; k++) step(4'h0, 32'h0, 1'b1, 4, "t6_no_stale");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
